// File: rtl/mac_sequencer.sv
// Job sequencer for the 8-bit multiply-accumulate path: clears the accumulator at job start,
// accumulates len operand-pair products with wrap-around and hands the result over valid/ready.
module mac_sequencer #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              abort,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  result,
    output logic              overflow
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   remaining;
    logic               ovf;

    logic               job_start;
    logic               beat;
    logic [PROD_W-1:0]  product;
    logic [SUM_W-1:0]   sum;
    logic               sum_ovf;

    // abort wins over a same-cycle beat, so the aborted pair never reaches acc.
    assign job_start = (state == IDLE) && start;
    assign beat      = (state == RUN) && in_valid && !abort;

    assign product = PROD_W'(a) * PROD_W'(b);
    assign sum     = SUM_W'(acc) + SUM_W'(product);
    assign sum_ovf = |sum[SUM_W-1:ACC_W];

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (beat && (remaining == CNT_W'(1))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            remaining <= '0;
            ovf       <= 1'b0;
        end else if (job_start) begin
            acc       <= '0;
            remaining <= len;
            ovf       <= 1'b0;
        end else if (beat) begin
            acc       <= sum[ACC_W-1:0];
            remaining <= remaining - CNT_W'(1);
            ovf       <= ovf | sum_ovf;
        end
    end

    // Handshake outputs depend on state only; result/overflow are masked outside DONE.
    assign in_ready  = (state == RUN);
    assign busy      = (state == RUN) || (state == DONE);
    assign res_valid = (state == DONE);
    assign result    = res_valid ? acc : '0;
    assign overflow  = res_valid ? ovf : 1'b0;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: hand-computed job results, stalls, overflow, zero length,
// backpressure, abort and asynchronous reset.
module tb_mac_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] len;
    logic       abort;
    logic       busy;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] result;
    logic       overflow;

    int tests  = 0;
    int failed = 0;

    mac_sequencer #(.DATA_W(8), .ACC_W(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle; inputs are changed only between edges.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
        len   = 8'hAA;
    endtask

    task automatic beat(input logic [7:0] x, input logic [7:0] y);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_done(input string tag, input logic [7:0] r, input logic o);
        check({tag, "_res_valid"}, res_valid, 1);
        check({tag, "_busy"},      busy,      1);
        check({tag, "_in_ready"},  in_ready,  0);
        check({tag, "_result"},    result,    r);
        check({tag, "_overflow"},  overflow,  o);
    endtask

    task automatic release_result(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_idle_busy"},   busy,      0);
        check({tag, "_idle_valid"},  res_valid, 0);
        check({tag, "_idle_result"}, result,    0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = 8'd0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        a         = 8'd0;
        b         = 8'd0;
        res_ready = 1'b0;

        #12;
        check("rst_busy",      busy,      0);
        check("rst_in_ready",  in_ready,  0);
        check("rst_res_valid", res_valid, 0);
        check("rst_result",    result,    0);
        check("rst_overflow",  overflow,  0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_in_ready", in_ready, 0);

        // 1: basic job, back-to-back pairs: 2*3 + 4*5 + 1*1 = 27
        start_job(8'd3);
        check("t1_run_in_ready", in_ready, 1);
        check("t1_run_busy",     busy,     1);
        beat(8'd2, 8'd3);
        check("t1_in_ready_b1", in_ready, 1);
        beat(8'd4, 8'd5);
        check("t1_in_ready_b2", in_ready,  1);
        check("t1_no_valid_b2", res_valid, 0);
        beat(8'd1, 8'd1);
        expect_done("t1", 8'd27, 1'b0);
        release_result("t1");

        // 2: same job with two idle cycles between pairs
        start_job(8'd3);
        beat(8'd2, 8'd3);
        tick();
        check("t2_stall_ready_a", in_ready,  1);
        tick();
        check("t2_stall_valid_a", res_valid, 0);
        beat(8'd4, 8'd5);
        tick();
        tick();
        check("t2_stall_ready_b", in_ready,  1);
        check("t2_stall_valid_b", res_valid, 0);
        beat(8'd1, 8'd1);
        expect_done("t2", 8'd27, 1'b0);
        release_result("t2");

        // 3: 225 + 100 = 325 -> 69 with overflow; next job clears the flag
        start_job(8'd2);
        beat(8'd15, 8'd15);
        beat(8'd10, 8'd10);
        expect_done("t3a", 8'd69, 1'b1);
        release_result("t3a");
        start_job(8'd1);
        beat(8'd3, 8'd3);
        expect_done("t3b", 8'd9, 1'b0);
        release_result("t3b");

        // 4a: zero length goes straight to DONE
        start_job(8'd0);
        expect_done("t4a", 8'd0, 1'b0);
        release_result("t4a");

        // 4b: backpressure holds 49; start during DONE is ignored
        start_job(8'd1);
        beat(8'd7, 8'd7);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len   = 8'd3;
            tick();
            check("t4b_hold_valid",  res_valid, 1);
            check("t4b_hold_result", result,    49);
        end
        start = 1'b1;
        len   = 8'd1;
        release_result("t4b");
        check("t4b_exit_start_ignored", in_ready, 0);
        start = 1'b0;
        tick();
        check("t4b_no_queue_busy", busy, 0);

        // 5: abort beats a same-cycle beat and yields no result
        start_job(8'd4);
        beat(8'd3, 8'd4);
        beat(8'd5, 8'd6);
        abort    = 1'b1;
        in_valid = 1'b1;
        a        = 8'd9;
        b        = 8'd9;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        check("t5_abort_busy",     busy,      0);
        check("t5_abort_in_ready", in_ready,  0);
        check("t5_abort_valid",    res_valid, 0);
        tick();
        check("t5_after_valid",    res_valid, 0);
        start_job(8'd1);
        beat(8'd2, 8'd2);
        expect_done("t5", 8'd4, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_done_abort_ignored", res_valid, 1);
        check("t5_done_abort_result",  result,    4);
        release_result("t5");

        // 6: asynchronous reset in the middle of a job
        start_job(8'd3);
        beat(8'd8, 8'd8);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy",     busy,      0);
        check("t6_rst_in_ready", in_ready,  0);
        check("t6_rst_valid",    res_valid, 0);
        check("t6_rst_result",   result,    0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("t6_post_rst_busy", busy, 0);
        start_job(8'd1);
        beat(8'd1, 8'd2);
        expect_done("t6", 8'd2, 1'b0);
        release_result("t6");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
